// File: rtl/systolic_pkg.sv
// Shared constants and FSM encoding for the systolic result transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_pkg;

    localparam logic [7:0] HDR_BYTE             = 8'hA5;
    localparam int         DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_HDR  = 2'd1,
        SEND_DATA = 2'd2,
        SEND_CSUM = 2'd3
    } tx_state_e;

endpackage

// File: rtl/systolic_result_tx_uart.sv
// UART 8N1 byte serializer; tx idles high, start/data(LSB first)/stop bits each CLKS_PER_BIT cycles.
// Latency: tx goes low the cycle after start is accepted; byte_done pulses in the last stop-bit cycle.
// Backpressure: start is taken only while ready; ready is also high in the byte_done cycle for gap-free chaining.
module uart_tx_byte
    import systolic_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       byte_done
);

    localparam int             CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             active;
    logic [3:0]       bit_idx;     // 0 = start bit, 1..8 = data, 9 = stop
    logic [CNT_W-1:0] baud_cnt;
    logic [8:0]       shift;       // remaining data bits followed by the stop bit
    logic             bit_end;

    assign bit_end   = active && (baud_cnt == CNT_LAST);
    assign byte_done = bit_end && (bit_idx == 4'd9);
    assign ready     = !active || byte_done;

    // Bit/baud sequencing; a start in the byte_done cycle reloads without an idle bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            bit_idx  <= 4'd0;
            baud_cnt <= '0;
            shift    <= '1;
            tx       <= 1'b1;
        end else if (start && ready) begin
            active   <= 1'b1;
            bit_idx  <= 4'd0;
            baud_cnt <= '0;
            shift    <= {1'b1, data};
            tx       <= 1'b0;
        end else if (byte_done) begin
            active   <= 1'b0;
            bit_idx  <= 4'd0;
            baud_cnt <= '0;
            tx       <= 1'b1;
        end else if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 4'd1;
            tx       <= shift[0];
            shift    <= {1'b1, shift[8:1]};
        end else if (active) begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/systolic_result_tx.sv
// Snapshots the N*N systolic results on capture and sends header, payload (LSB byte first) and XOR checksum over UART.
// Latency: start bit the cycle after acceptance; done (2 + N*N*DATA_W/8)*10*CLKS_PER_BIT cycles after acceptance.
// Backpressure: none upstream; a capture while busy is dropped and flagged in sticky overrun.
module systolic_result_tx
    import systolic_pkg::*;
#(
    parameter int N            = 2,
    parameter int DATA_W       = 32,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  capture,
    input  logic [N*N*DATA_W-1:0] c_flat,
    output logic                  tx,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int               NBYTES   = N * N * DATA_W / 8;
    localparam int               IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    tx_state_e             state, state_nxt;
    logic [N*N*DATA_W-1:0] cap_buf;
    logic [IDX_W-1:0]      byte_idx;   // payload byte currently on the line
    logic [IDX_W-1:0]      pay_sel;    // payload byte to load next
    logic [7:0]            pay_byte;
    logic [7:0]            csum;
    logic                  accept;
    logic                  load_pay;
    logic                  u_start;
    logic [7:0]            u_data;
    logic                  u_ready;
    logic                  u_byte_done;

    assign accept   = capture && !busy;
    assign pay_sel  = (state == SEND_DATA) ? byte_idx + IDX_W'(1) : '0;
    assign pay_byte = 8'(cap_buf >> {pay_sel, 3'b000});

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (u_start),
        .data     (u_data),
        .tx       (tx),
        .ready    (u_ready),
        .byte_done(u_byte_done)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and byte hand-off; the next byte is offered in the byte_done cycle.
    always_comb begin
        state_nxt = state;
        u_start   = 1'b0;
        u_data    = HDR_BYTE;
        load_pay  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    u_start   = 1'b1;
                    u_data    = HDR_BYTE;
                    state_nxt = SEND_HDR;
                end
            end
            SEND_HDR: begin
                if (u_byte_done) begin
                    u_start   = 1'b1;
                    u_data    = pay_byte;
                    load_pay  = 1'b1;
                    state_nxt = SEND_DATA;
                end
            end
            SEND_DATA: begin
                if (u_byte_done) begin
                    u_start = 1'b1;
                    if (byte_idx == IDX_LAST) begin
                        u_data    = csum;
                        state_nxt = SEND_CSUM;
                    end else begin
                        u_data   = pay_byte;
                        load_pay = 1'b1;
                    end
                end
            end
            SEND_CSUM: begin
                if (u_byte_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture buffer, checksum, payload index and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_buf  <= '0;
            byte_idx <= '0;
            csum     <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            done <= (state == SEND_CSUM) && u_byte_done;
            if (capture && busy) overrun <= 1'b1;
            if (accept) begin
                cap_buf <= c_flat;
                csum    <= 8'h00;
                busy    <= 1'b1;
            end else if ((state == SEND_CSUM) && u_byte_done) begin
                busy <= 1'b0;
            end
            if (load_pay) csum <= csum ^ pay_byte;
            if ((state == SEND_DATA) && u_byte_done)
                byte_idx <= (byte_idx == IDX_LAST) ? '0 : byte_idx + IDX_W'(1);
        end
    end

endmodule
